// File: rtl/dma_rd_engine_if.sv
// Host-side DMA read channel bundle: peripheral-facing FIFO port plus memory request/response.
// The slave modport is the read engine; the master modport is the DMAC/memory side.
interface dma_rd_engine_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SIZE_WIDTH = 16
);
    logic                  rd_go;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [SIZE_WIDTH-1:0] rd_size;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  rd_en;
    logic                  rd_done;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;
    logic                  err;

    modport master (
        output rd_go, rd_addr, rd_size, rd_en, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  rd_data, empty, rd_done, mem_req_valid, mem_req_addr, err
    );

    modport slave (
        input  rd_go, rd_addr, rd_size, rd_en, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output rd_data, empty, rd_done, mem_req_valid, mem_req_addr, err
    );
endinterface

// File: rtl/dma_rd_engine.sv
// DMA read engine: splits a transfer into single-word memory reads under a FIFO credit limit
// and presents in-order responses through a show-ahead FIFO with a sticky done flag.
module dma_rd_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SIZE_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input logic            clk,
    input logic            rst,
    dma_rd_engine_if.slave bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [CntW:0] DepthW = (CntW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d;
    logic [SIZE_WIDTH-1:0] req_cnt_q, req_cnt_d;
    logic [CntW-1:0]       outst_q, outst_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic            req_hs;
    logic            rsp_push;
    logic            rsp_stray;
    logic            pop;
    logic            credit;
    logic [CntW:0]   inflight_d;

    always_comb begin
        req_hs    = valid_q & bus.mem_req_ready;
        rsp_push  = bus.mem_rsp_valid & (outst_q != '0);
        rsp_stray = bus.mem_rsp_valid & (outst_q == '0);
        pop       = bus.rd_en & (count_q != '0);

        outst_d  = outst_q + CntW'(req_hs) - CntW'(rsp_push);
        count_d  = count_q + CntW'(rsp_push) - CntW'(pop);
        wr_ptr_d = rsp_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        // A raised valid reserves a FIFO slot, so only raise it while a slot is free.
        inflight_d = {1'b0, outst_d} + {1'b0, count_d};
        credit     = inflight_d < DepthW;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        size_d    = size_q;
        req_cnt_d = req_cnt_q;
        done_d    = done_q;
        err_d     = err_q | rsp_stray;

        case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone) begin
                    done_d = 1'b1;
                end
                if (bus.rd_go) begin
                    addr_d    = bus.rd_addr;
                    size_d    = bus.rd_size;
                    req_cnt_d = '0;
                    done_d    = 1'b0;
                    if (bus.rd_size == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                        valid_d = credit;
                    end
                end
            end
            StIssue: begin
                if (req_hs) begin
                    addr_d    = addr_q + AddrStep;
                    req_cnt_d = req_cnt_q + 1'b1;
                end
                if (req_hs && (req_cnt_d == size_q)) begin
                    valid_d = 1'b0;
                    state_d = StDrain;
                end else begin
                    valid_d = (valid_q & ~req_hs) | credit;
                end
            end
            StDrain: begin
                // Look at next-state counts so done rises the cycle after the final pop.
                if ((outst_d == '0) && (count_d == '0)) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            size_q    <= '0;
            req_cnt_q <= '0;
            outst_q   <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            size_q    <= size_d;
            req_cnt_q <= req_cnt_d;
            outst_q   <= outst_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_push) begin
            mem_q[wr_ptr_q] <= bus.mem_rsp_data;
        end
    end

    assign bus.mem_req_valid = valid_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.rd_done       = done_q;
    assign bus.err           = err_q;
    assign bus.empty         = (count_q == '0);
    // Storage is not reset, so mask the head word while empty.
    assign bus.rd_data       = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
endmodule

// File: tb/tb_dma_rd_engine.sv
// Randomized bench for dma_rd_engine: a queue-based memory and FIFO model predicts
// request addresses, popped words, empty, err and rd_done timing cycle by cycle.
module tb_dma_rd_engine;
    localparam int Depth = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_rd_engine_if bus ();
    dma_rd_engine dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [31:0] req_exp[$];
    logic [31:0] pop_exp[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          hs_cyc[$];

    int hs_cnt = 0, pop_cnt = 0, out_model = 0, fifo_model = 0;
    int ready_pct = 100, rden_pct = 100, lat_min = 1, lat_max = 1;
    int stall_left = 0, inj_cyc = -1, go_cyc = 0, first_valid_cyc = -1;
    bit rden_hold = 0, chk_done = 0, done_exp = 0, done_seen = 0, prev_stall = 0, err_exp = 0;
    logic [31:0] prev_addr = '0;
    logic [31:0] salt = '0;

    // One clock of memory model, FIFO model and checks; inputs change at the negedge.
    task automatic drive_cycle();
        bit hs, push, pop, injected;
        int lat;
        injected = 0;
        if (cyc == inj_cyc) begin
            bus.rd_go = 1'b1; bus.rd_addr = 32'h9000; bus.rd_size = 16'd3; injected = 1;
        end
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = pend_addr.pop_front() ^ salt;
            void'(pend_due.pop_front());
        end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = $urandom;
        end
        if (stall_left > 0) begin
            bus.mem_req_ready = 1'b0;
            stall_left--;
        end else begin
            bus.mem_req_ready = (int'($urandom_range(99)) < ready_pct);
        end
        bus.rd_en = rden_hold ? 1'b0 : (int'($urandom_range(99)) < rden_pct);

        if (prev_stall) begin
            vectors++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== prev_addr) begin
                miscompares++;
                $display("FAIL req_hold: got valid=%b addr=%h, expected valid=1 addr=%h",
                         bus.mem_req_valid, bus.mem_req_addr, prev_addr);
            end
        end
        vectors++;
        if (bus.empty !== (fifo_model == 0)) begin
            miscompares++;
            $display("FAIL empty: got %b, expected %b (model count %0d)", bus.empty,
                     fifo_model == 0, fifo_model);
        end
        if (fifo_model > 0) begin
            vectors++;
            if (bus.rd_data !== pop_exp[0]) begin
                miscompares++;
                $display("FAIL rd_data: got %h, expected %h", bus.rd_data, pop_exp[0]);
            end
        end
        vectors++;
        if (bus.err !== err_exp) begin
            miscompares++;
            $display("FAIL err: got %b, expected %b", bus.err, err_exp);
        end
        if (chk_done) begin
            vectors++;
            if (bus.rd_done !== done_exp) begin
                miscompares++;
                $display("FAIL rd_done: got %b, expected %b at cycle %0d", bus.rd_done, done_exp,
                         cyc - go_cyc);
            end
            if (done_exp) done_seen = 1;
        end
        if (bus.mem_req_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;

        hs   = (bus.mem_req_valid === 1'b1) && bus.mem_req_ready;
        push = bus.mem_rsp_valid && (out_model > 0);
        pop  = bus.rd_en && (fifo_model > 0);
        if (hs) begin
            vectors++;
            if (req_exp.size() == 0) begin
                miscompares++;
                $display("FAIL extra_req: got addr %h, expected no request", bus.mem_req_addr);
            end else begin
                if (bus.mem_req_addr !== req_exp[0]) begin
                    miscompares++;
                    $display("FAIL req_addr: got %h, expected %h", bus.mem_req_addr, req_exp[0]);
                end
                void'(req_exp.pop_front());
            end
            lat = lat_min + int'($urandom_range(lat_max - lat_min));
            pend_addr.push_back(bus.mem_req_addr);
            pend_due.push_back(cyc + lat);
            hs_cyc.push_back(cyc);
            hs_cnt++;
        end
        if (pop) begin
            void'(pop_exp.pop_front());
            pop_cnt++;
            if (chk_done && pop_exp.size() == 0 && req_exp.size() == 0) done_exp = 1;
        end
        out_model  += int'(hs) - int'(push);
        fifo_model += int'(push) - int'(pop);
        vectors++;
        if (hs_cnt - pop_cnt > Depth) begin
            miscompares++;
            $display("FAIL credit: got %0d words in flight, expected at most %0d",
                     hs_cnt - pop_cnt, Depth);
        end
        prev_stall = (bus.mem_req_valid === 1'b1) && !bus.mem_req_ready;
        prev_addr  = bus.mem_req_addr;
        @(negedge clk);
        cyc++;
        if (injected) bus.rd_go = 1'b0;
    endtask

    task automatic start_xfer(input logic [31:0] a, input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            req_exp.push_back(a + 32'(4 * i));
            pop_exp.push_back((a + 32'(4 * i)) ^ salt);
        end
        hs_cnt = 0; pop_cnt = 0; hs_cyc.delete(); first_valid_cyc = -1;
        done_exp = 0; done_seen = 0; chk_done = 0;
        bus.rd_go = 1'b1; bus.rd_addr = a; bus.rd_size = 16'(n); go_cyc = cyc;
        drive_cycle();
        bus.rd_go = 1'b0; bus.rd_addr = $urandom; bus.rd_size = 16'($urandom);
        chk_done = 1;
        if (n == 0) begin
            drive_cycle();
            done_exp = 1;
        end
    endtask

    task automatic finish_xfer(input int tmo);
        int t = 0;
        while (!done_seen && t < tmo) begin
            drive_cycle();
            t++;
        end
        vectors++;
        if (!done_seen || req_exp.size() != 0 || pop_exp.size() != 0) begin
            miscompares++;
            $display("FAIL xfer_end: got done=%b reqs_left=%0d words_left=%0d, expected 1/0/0",
                     done_seen, req_exp.size(), pop_exp.size());
        end
        repeat (3) drive_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vectors += 6;
        if (bus.mem_req_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_valid: got %b, expected 0", bus.mem_req_valid);
        end
        if (bus.mem_req_addr !== 32'h0) begin
            miscompares++; $display("FAIL rst_addr: got %h, expected 0", bus.mem_req_addr);
        end
        if (bus.rd_done !== 1'b0) begin
            miscompares++; $display("FAIL rst_done: got %b, expected 0", bus.rd_done);
        end
        if (bus.err !== 1'b0) begin
            miscompares++; $display("FAIL rst_err: got %b, expected 0", bus.err);
        end
        if (bus.empty !== 1'b1) begin
            miscompares++; $display("FAIL rst_empty: got %b, expected 1", bus.empty);
        end
        if (bus.rd_data !== 32'h0) begin
            miscompares++; $display("FAIL rst_data: got %h, expected 0", bus.rd_data);
        end
    endtask

    task automatic test_basic();
        salt = '0; lat_min = 1; lat_max = 1; ready_pct = 100; rden_pct = 100; rden_hold = 0;
        start_xfer(32'h1000, 4);
        finish_xfer(50);
        vectors++;
        if (first_valid_cyc != go_cyc + 1) begin
            miscompares++;
            $display("FAIL basic_first_valid: got cycle %0d, expected 1", first_valid_cyc - go_cyc);
        end
        vectors++;
        if (hs_cyc.size() != 4) begin
            miscompares++; $display("FAIL basic_hs_count: got %0d, expected 4", hs_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (hs_cyc[i] != go_cyc + 1 + i) begin
                    miscompares++;
                    $display("FAIL basic_b2b: request %0d got cycle %0d, expected %0d", i,
                             hs_cyc[i] - go_cyc, 1 + i);
                end
            end
        end
    endtask

    task automatic test_credit();
        salt = $urandom; lat_min = 1; lat_max = 3; ready_pct = 100; rden_hold = 1;
        start_xfer(32'h2000, 20);
        repeat (30) drive_cycle();
        vectors += 2;
        if (hs_cnt != 16) begin
            miscompares++; $display("FAIL credit_stop: got %0d requests, expected 16", hs_cnt);
        end
        if (bus.mem_req_valid !== 1'b0) begin
            miscompares++; $display("FAIL credit_valid: got %b, expected 0", bus.mem_req_valid);
        end
        rden_hold = 0; rden_pct = 100;
        repeat (4) drive_cycle();
        rden_hold = 1;
        repeat (12) drive_cycle();
        vectors += 2;
        if (hs_cnt != 20) begin
            miscompares++; $display("FAIL credit_resume: got %0d requests, expected 20", hs_cnt);
        end
        if (pop_cnt != 4) begin
            miscompares++; $display("FAIL credit_pops: got %0d pops, expected 4", pop_cnt);
        end
        rden_hold = 0; rden_pct = 60;
        finish_xfer(300);
    endtask

    task automatic test_zero_busy();
        salt = $urandom; lat_min = 1; lat_max = 2; ready_pct = 100; rden_pct = 100;
        start_xfer(32'h3000, 0);
        finish_xfer(10);
        vectors++;
        if (first_valid_cyc != -1) begin
            miscompares++;
            $display("FAIL zero_no_req: got valid at cycle %0d, expected none",
                     first_valid_cyc - go_cyc);
        end
        inj_cyc = cyc + 3;
        start_xfer(32'h5000, 8);
        finish_xfer(80);
        inj_cyc = -1;
        vectors++;
        if (hs_cnt != 8) begin
            miscompares++; $display("FAIL busy_go: got %0d requests, expected 8", hs_cnt);
        end
    endtask

    task automatic test_stall_wrap();
        salt = '0; lat_min = 1; lat_max = 1; ready_pct = 100; rden_pct = 100;
        stall_left = 6;
        start_xfer(32'hFFFF_FFFC, 2);
        finish_xfer(40);
        vectors++;
        if (hs_cyc.size() != 2 || hs_cyc[0] != go_cyc + 6 || hs_cyc[1] != go_cyc + 7) begin
            miscompares++;
            $display("FAIL stall_timing: got %0d requests, first at cycle %0d, expected 2 at 6",
                     hs_cyc.size(), (hs_cyc.size() > 0) ? hs_cyc[0] - go_cyc : -1);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            salt = $urandom;
            ready_pct = 30 + int'($urandom_range(70));
            rden_pct  = 20 + int'($urandom_range(80));
            lat_min = 1; lat_max = 1 + int'($urandom_range(3));
            start_xfer($urandom & 32'hFFFF_FFFC, 1 + $urandom_range(39));
            finish_xfer(3000);
        end
    endtask

    task automatic test_reset_stray();
        int t = 0;
        salt = '0; lat_min = 50; lat_max = 50; ready_pct = 100; rden_pct = 100;
        start_xfer(32'h7000, 8);
        while (hs_cnt < 3 && t < 20) begin
            drive_cycle();
            t++;
        end
        rst = 1'b1; bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        req_exp.delete(); pop_exp.delete(); pend_addr.delete(); pend_due.delete();
        out_model = 0; fifo_model = 0; chk_done = 0; prev_stall = 0;
        vectors += 3;
        if (bus.empty !== 1'b1) begin
            miscompares++; $display("FAIL mid_rst_empty: got %b, expected 1", bus.empty);
        end
        if (bus.mem_req_valid !== 1'b0) begin
            miscompares++; $display("FAIL mid_rst_valid: got %b, expected 0", bus.mem_req_valid);
        end
        if (bus.rd_done !== 1'b0) begin
            miscompares++; $display("FAIL mid_rst_done: got %b, expected 0", bus.rd_done);
        end
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = $urandom;
        @(negedge clk);
        cyc++;
        bus.mem_rsp_valid = 1'b0;
        err_exp = 1;
        vectors += 2;
        if (bus.err !== 1'b1) begin
            miscompares++; $display("FAIL stray_err: got %b, expected 1", bus.err);
        end
        if (bus.empty !== 1'b1) begin
            miscompares++; $display("FAIL stray_empty: got %b, expected 1", bus.empty);
        end
        // A fresh transfer is only accepted if the FSM really returned to idle.
        lat_min = 1; lat_max = 1;
        start_xfer(32'h8000, 3);
        finish_xfer(40);
    endtask

    initial begin
        bus.rd_go = 1'b0; bus.rd_addr = '0; bus.rd_size = '0; bus.rd_en = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
        test_reset();
        test_basic();
        test_credit();
        test_zero_busy();
        test_stall_wrap();
        test_random();
        test_reset_stray();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
